rstn_sequencer: RTL and testbench
=================================

RSTN_SEQUENCER -- requirements
Module: rstn_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the reset-deassertion synchronizer depth (legal: 2..4).
REQ-002 Parameter NUM_OUT, default 4, SHALL set the number of sequenced downstream active-low reset outputs (legal: 1..16).
REQ-003 Parameter GAP, default 3, SHALL set the clock cycles between successive output releases (legal: 1..15).
REQ-004 Parameter HOLD_CYC, default 4, SHALL set the clock cycles a soft reset holds outputs low before acknowledging (legal: 1..15).
REQ-005 CLK  input  1  SHALL be the single clock; all state changes on its rising edge except async reset.
REQ-006 RN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 SOFT_REQ  input  1  SHALL be the soft-reset request level (4-phase handshake with SOFT_ACK).
REQ-008 SOFT_ACK  output  1  SHALL be the soft-reset acknowledge; high means the hold is complete.
REQ-009 RN_OUT  output  NUM_OUT  SHALL be the active-low resets driving downstream flop RN pins; bit 0 releases first.
REQ-010 READY  output  1  SHALL be high only when all RN_OUT bits are released and the block is in RUN.

Function
REQ-011 The state machine SHALL have states SYNC, RELEASE, RUN, HOLD and ACK, with SYNC as the reset state.
REQ-012 SYNC: a SYNC_STAGES-deep flop chain, cleared asynchronously by RN and fed a constant 1, SHALL transition to RELEASE on the edge its last stage becomes high.
REQ-013 Edge numbering: the first rising edge with RN high is edge 1, and the synchronized reset is high after edge SYNC_STAGES.
REQ-014 RELEASE: RN_OUT[i] SHALL go high after edge SYNC_STAGES+1+i*GAP, and bits already high SHALL stay high.
REQ-015 RELEASE: READY SHALL go high one edge after RN_OUT[NUM_OUT-1] goes high, and the state SHALL become RUN on that edge. With defaults, RN_OUT[0..3] go high after edges 3, 6, 9 and 12, and READY after edge 13.
REQ-016 RUN: when SOFT_REQ is sampled high at edge k, then after edge k all RN_OUT bits SHALL be 0, READY SHALL be 0, and the state SHALL become HOLD.
REQ-017 HOLD: SOFT_ACK SHALL go high after edge k+HOLD_CYC, and the state SHALL become ACK on that edge; RN_OUT SHALL stay all-zero.
REQ-018 ACK: when SOFT_REQ is sampled low at edge m, then after edge m SOFT_ACK SHALL be 0 and the state SHALL become RELEASE.
REQ-019 Release from ACK: RN_OUT[i] SHALL go high after edge m+1+i*GAP, and READY after edge m+2+(NUM_OUT-1)*GAP.
REQ-020 SOFT_REQ SHALL be ignored in SYNC, RELEASE and HOLD.
REQ-021 A SOFT_REQ still high on entry to RUN SHALL be serviced on the first RUN edge that samples it high.
REQ-022 SOFT_REQ dropping during HOLD SHALL NOT shorten the hold.
REQ-023 ACK with SOFT_REQ held high SHALL hold indefinitely: outputs low, SOFT_ACK high.
REQ-024 The GAP spacing counter and the HOLD counter SHALL be 4 bits wide and SHALL reload to 0 on every state entry and after each release step; they SHALL NOT wrap.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from SOFT_REQ to any output.
REQ-026 NUM_OUT=1 SHALL release RN_OUT[0] at the first RELEASE step and assert READY one edge later.

Reset
REQ-027 RN low SHALL asynchronously force RN_OUT all-zero, READY=0 and SOFT_ACK=0, clear the synchronizer and counters, and set the state to SYNC, regardless of CLK.
REQ-028 RN asserted in any state, including mid-RELEASE or mid-HOLD, SHALL abort the operation; after RN rises, sequencing SHALL restart from REQ-013.
REQ-029 A RN pulse shorter than one CLK period SHALL still produce the full REQ-027 response.

Verification
REQ-030 Power-on, defaults: RN low 5 cycles then high, SOFT_REQ=0 -> RN_OUT = 0000, 0001, 0011, 0111, 1111 after edges 3, 6, 9, 12 respectively; READY=1 after edge 13.
REQ-031 Soft reset: in RUN, SOFT_REQ=1 sampled at edge k -> RN_OUT=0000 and READY=0 after k; SOFT_ACK=1 after k+4; SOFT_REQ=0 sampled at m -> SOFT_ACK=0 after m; RN_OUT[0]=1 after m+1; READY=1 after m+11.
REQ-032 Mid-sequence reset: RN pulsed low between edges 7 and 8 of power-on -> outputs 0 immediately; full REQ-030 timeline repeats from the new edge 1.
REQ-033 Early request: SOFT_REQ high from edge 1 -> no effect through RELEASE; READY pulses high for exactly the one cycle after edge 13; HOLD entered at edge 14; SOFT_ACK=1 after edge 18.
REQ-034 Glitch and parameter sweep: RN low for half a CLK period produces the REQ-027 response. NUM_OUT=1, GAP=1, HOLD_CYC=1, SYNC_STAGES=3 -> RN_OUT[0]=1 after edge 4 and READY after edge 5; soft hold gives SOFT_ACK one edge after entering HOLD.

Source files
------------

// File: rtl/rstn_sequencer_if.sv
// Soft-reset handshake and sequenced reset outputs of rstn_sequencer.
//   soft_req : soft-reset request level (4-phase with soft_ack)
//   soft_ack : high once the soft-reset hold has completed
//   rn_out   : active-low downstream resets, bit 0 releases first
//   ready    : all rn_out released and sequencer running
// master = requester / reset consumer side, slave = the sequencer.
interface rstn_sequencer_if #(
   parameter int NUM_OUT = 4
);
   logic               soft_req;
   logic               soft_ack;
   logic [NUM_OUT-1:0] rn_out;
   logic               ready;

   modport master (output soft_req, input soft_ack, input rn_out, input ready);
   modport slave  (input soft_req, output soft_ack, output rn_out, output ready);
endinterface

// File: rtl/rstn_sequencer.sv
// Reset sequencer: synchronizes the deassertion of the async reset rn, then
// releases NUM_OUT downstream active-low resets one at a time, GAP cycles
// apart. In RUN a soft-reset request pulls every output low, holds it for
// HOLD_CYC cycles, acknowledges, and re-runs the release sequence once the
// request drops.
//   clk : clock
//   rn  : asynchronous active-low reset
//   bus : rstn_sequencer_if.slave (soft_req in; soft_ack, rn_out, ready out)
// All outputs come straight from flops.
module rstn_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 4,
   parameter int GAP         = 3,
   parameter int HOLD_CYC    = 4
) (
   input  logic               clk,
   input  logic               rn,
   rstn_sequencer_if.slave    bus
);

   localparam logic [3:0] GAP_M1  = 4'(GAP - 1);
   localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_SYNC,
      S_RELEASE,
      S_RUN,
      S_HOLD,
      S_ACK
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic [3:0]             cnt, cnt_nxt, cnt_inc;
   logic [NUM_OUT-1:0]     rn_out_q, rn_out_nxt;
   logic                   ready_q, ready_nxt;
   logic                   ack_q, ack_nxt;
   logic                   sync_rise;

   // Deassertion synchronizer: cleared asynchronously, shifts in ones.
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], 1'b1};
   end

   // True on the edge where the last stage turns high, so the FSM enters
   // RELEASE on that same edge.
   assign sync_rise = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];

   // Saturating: the counters never wrap.
   assign cnt_inc = (cnt == 4'hf) ? cnt : cnt + 4'd1;

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state    <= S_SYNC;
         cnt      <= '0;
         rn_out_q <= '0;
         ready_q  <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rn_out_q <= rn_out_nxt;
         ready_q  <= ready_nxt;
         ack_q    <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      rn_out_nxt = rn_out_q;
      ready_nxt  = ready_q;
      ack_nxt    = ack_q;
      case (state)
         S_SYNC: begin
            if (sync_rise) begin
               state_nxt = S_RELEASE;
               cnt_nxt   = '0;
            end
         end
         S_RELEASE: begin
            if (rn_out_q[NUM_OUT-1]) begin
               state_nxt = S_RUN;
               ready_nxt = 1'b1;
               cnt_nxt   = '0;
            end else if (!rn_out_q[0] || cnt == GAP_M1) begin
               // First step fires on the first RELEASE edge, later ones
               // every GAP edges; released bits are kept.
               rn_out_nxt = (rn_out_q << 1) | NUM_OUT'(1);
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_RUN: begin
            if (bus.soft_req) begin
               state_nxt  = S_HOLD;
               rn_out_nxt = '0;
               ready_nxt  = 1'b0;
               cnt_nxt    = '0;
            end
         end
         S_HOLD: begin
            // Request level is not looked at: the hold always runs out.
            if (cnt == HOLD_M1) begin
               state_nxt = S_ACK;
               ack_nxt   = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_ACK: begin
            if (!bus.soft_req) begin
               state_nxt = S_RELEASE;
               ack_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   assign bus.rn_out   = rn_out_q;
   assign bus.ready    = ready_q;
   assign bus.soft_ack = ack_q;

endmodule

// File: tb/tb_rstn_sequencer.sv
// Bench for rstn_sequencer: DUT0 uses default parameters, DUT1 uses
// SYNC_STAGES=3, NUM_OUT=1, GAP=1, HOLD_CYC=1. Directed timeline checks
// followed by random soft requests and short reset pulses, compared every
// cycle against a timestamp-based reference model.
module tb_rstn_sequencer;

   localparam int P_SEQ  = 0;
   localparam int P_RUN  = 1;
   localparam int P_HOLD = 2;
   localparam int P_ACK  = 3;

   int pS[2] = '{2, 3};
   int pN[2] = '{4, 1};
   int pG[2] = '{3, 1};
   int pH[2] = '{4, 1};

   typedef struct {
      int n;   // rising edges seen since reset released
      int ph;
      int o;   // edge at which the current release sequence started
      int k;   // edge at which the soft request was taken
   } mdl_t;

   logic clk = 1'b0;
   logic rn0, rn1;
   int   n_cmp = 0;
   int   n_mis = 0;
   mdl_t m0, m1;

   rstn_sequencer_if #(.NUM_OUT(4)) bus0 ();
   rstn_sequencer_if #(.NUM_OUT(1)) bus1 ();

   rstn_sequencer u_dut0 (
      .clk (clk),
      .rn  (rn0),
      .bus (bus0)
   );

   rstn_sequencer #(
      .SYNC_STAGES (3),
      .NUM_OUT     (1),
      .GAP         (1),
      .HOLD_CYC    (1)
   ) u_dut1 (
      .clk (clk),
      .rn  (rn1),
      .bus (bus1)
   );

   always #10 clk = ~clk;

   function automatic mdl_t mdl_reset(input int d);
      mdl_t r;
      r.n  = 0;
      r.ph = P_SEQ;
      r.o  = pS[d];
      r.k  = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(input int d, input mdl_t m, input logic sreq);
      mdl_t r;
      r   = m;
      r.n = m.n + 1;
      case (m.ph)
         P_SEQ:  if (r.n - m.o >= 2 + (pN[d] - 1) * pG[d]) r.ph = P_RUN;
         P_RUN:  if (sreq) begin r.ph = P_HOLD; r.k = r.n; end
         P_HOLD: if (r.n >= m.k + pH[d]) r.ph = P_ACK;
         default: if (!sreq) begin r.ph = P_SEQ; r.o = r.n; end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] exp_rn(input int d, input mdl_t m);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < pN[d]; i++)
         if (m.ph == P_RUN || (m.ph == P_SEQ && m.n - m.o >= 1 + i * pG[d]))
            r[i] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rn0)
      if (!rn0) m0 <= mdl_reset(0);
      else      m0 <= mdl_step(0, m0, bus0.soft_req);

   always @(posedge clk or negedge rn1)
      if (!rn1) m1 <= mdl_reset(1);
      else      m1 <= mdl_step(1, m1, bus1.soft_req);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_chk();
      chk("mdl_rn_out0", 32'(bus0.rn_out), exp_rn(0, m0));
      chk("mdl_ready0",  32'(bus0.ready), 32'(m0.ph == P_RUN));
      chk("mdl_ack0",    32'(bus0.soft_ack), 32'(m0.ph == P_ACK));
      chk("mdl_rn_out1", 32'(bus1.rn_out), exp_rn(1, m1));
      chk("mdl_ready1",  32'(bus1.ready), 32'(m1.ph == P_RUN));
      chk("mdl_ack1",    32'(bus1.soft_ack), 32'(m1.ph == P_ACK));
   endtask

   // One clock: check after the rising edge, return 2 units past the
   // falling edge where inputs are driven.
   task automatic cyc();
      @(negedge clk);
      model_chk();
      #2;
   endtask

   // Absolute release timeline, e = edges since reset went high.
   task automatic por(input bit c0, input bit c1);
      logic [3:0] tbl [0:13];
      tbl = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3,
              4'h7, 4'h7, 4'h7, 4'hf, 4'hf};
      for (int e = 1; e <= 13; e++) begin
         cyc();
         if (c0) begin
            chk($sformatf("por_rn_out0_e%0d", e), 32'(bus0.rn_out), 32'(tbl[e]));
            chk($sformatf("por_ready0_e%0d", e), 32'(bus0.ready), 32'(e >= 13));
            chk($sformatf("por_ack0_e%0d", e), 32'(bus0.soft_ack), 32'd0);
         end
         if (c1) begin
            chk($sformatf("por_rn_out1_e%0d", e), 32'(bus1.rn_out), 32'(e >= 4));
            chk($sformatf("por_ready1_e%0d", e), 32'(bus1.ready), 32'(e >= 5));
         end
      end
   endtask

   initial begin
      int r;
      rn0 = 1'b0;
      rn1 = 1'b0;
      bus0.soft_req = 1'b0;
      bus1.soft_req = 1'b0;
      repeat (5) cyc();
      chk("rst_rn_out0", 32'(bus0.rn_out), 32'd0);
      chk("rst_ready0",  32'(bus0.ready), 32'd0);
      chk("rst_ack0",    32'(bus0.soft_ack), 32'd0);
      chk("rst_rn_out1", 32'(bus1.rn_out), 32'd0);
      rn0 = 1'b1;
      rn1 = 1'b1;
      por(1'b1, 1'b1);

      // Soft reset round trip on both DUTs.
      bus0.soft_req = 1'b1;
      bus1.soft_req = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         cyc();
         if (j == 1) begin
            chk("soft_rn_out0_k",  32'(bus0.rn_out), 32'd0);
            chk("soft_ready0_k",   32'(bus0.ready), 32'd0);
            chk("soft_rn_out1_k",  32'(bus1.rn_out), 32'd0);
            chk("soft_ready1_k",   32'(bus1.ready), 32'd0);
            chk("soft_ack1_k",     32'(bus1.soft_ack), 32'd0);
         end
         if (j == 2) chk("soft_ack1_k1", 32'(bus1.soft_ack), 32'd1);
         if (j == 4) chk("soft_ack0_k3", 32'(bus0.soft_ack), 32'd0);
         if (j == 5) chk("soft_ack0_k4", 32'(bus0.soft_ack), 32'd1);
         if (j == 6) begin
            chk("soft_ack0_held",    32'(bus0.soft_ack), 32'd1);
            chk("soft_rn_out0_held", 32'(bus0.rn_out), 32'd0);
         end
      end
      bus0.soft_req = 1'b0;
      bus1.soft_req = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         cyc();
         if (j == 1) begin
            chk("soft_ack0_m",    32'(bus0.soft_ack), 32'd0);
            chk("soft_ack1_m",    32'(bus1.soft_ack), 32'd0);
            chk("soft_rn_out0_m", 32'(bus0.rn_out), 32'd0);
         end
         if (j == 2) begin
            chk("soft_rn_out0_m1", 32'(bus0.rn_out), 32'h1);
            chk("soft_rn_out1_m1", 32'(bus1.rn_out), 32'h1);
            chk("soft_ready1_m1",  32'(bus1.ready), 32'd0);
         end
         if (j == 3)  chk("soft_ready1_m2",   32'(bus1.ready), 32'd1);
         if (j == 11) begin
            chk("soft_rn_out0_m10", 32'(bus0.rn_out), 32'hf);
            chk("soft_ready0_m10",  32'(bus0.ready), 32'd0);
         end
         if (j == 12) chk("soft_ready0_m11", 32'(bus0.ready), 32'd1);
      end

      // Short reset pulses, the second one mid-release.
      rn0 = 1'b0;
      #1;
      chk("pulse_rn_out0", 32'(bus0.rn_out), 32'd0);
      chk("pulse_ready0",  32'(bus0.ready), 32'd0);
      #2 rn0 = 1'b1;
      repeat (7) cyc();
      rn0 = 1'b0;
      #1;
      chk("midseq_rn_out0", 32'(bus0.rn_out), 32'd0);
      #2 rn0 = 1'b1;
      por(1'b1, 1'b0);

      // Request already high while the sequence runs.
      bus0.soft_req = 1'b1;
      rn0 = 1'b0;
      #1;
      chk("early_rn_out0", 32'(bus0.rn_out), 32'd0);
      #2 rn0 = 1'b1;
      por(1'b1, 1'b0);
      for (int e = 14; e <= 18; e++) begin
         cyc();
         if (e == 14) begin
            chk("early_ready0_e14",  32'(bus0.ready), 32'd0);
            chk("early_rn_out0_e14", 32'(bus0.rn_out), 32'd0);
         end
         if (e == 17) chk("early_ack0_e17", 32'(bus0.soft_ack), 32'd0);
         if (e == 18) chk("early_ack0_e18", 32'(bus0.soft_ack), 32'd1);
      end
      bus0.soft_req = 1'b0;

      // Half-period reset glitch on DUT1 while it is running.
      #10;
      rn1 = 1'b0;
      #1;
      chk("glitch_rn_out1", 32'(bus1.rn_out), 32'd0);
      chk("glitch_ready1",  32'(bus1.ready), 32'd0);
      #9 rn1 = 1'b1;
      por(1'b0, 1'b1);

      // Random soft requests and reset pulses against the model.
      for (int c = 0; c < 1500; c++) begin
         cyc();
         if ($urandom_range(0, 3) == 0) bus0.soft_req = ~bus0.soft_req;
         if ($urandom_range(0, 3) == 0) bus1.soft_req = ~bus1.soft_req;
         r = $urandom_range(0, 299);
         if (r == 0) begin
            rn0 = 1'b0;
            #($urandom_range(1, 6));
            rn0 = 1'b1;
         end else if (r == 1) begin
            rn1 = 1'b0;
            #($urandom_range(1, 6));
            rn1 = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
